// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// Handshake: the master raises start with a_in/b_in valid. The slave accepts
// start only while not busy (IDLE or DONE), and start is ignored while busy.
// Completion is signalled by a one-cycle done pulse, with product_out valid
// from that same edge. product_out then holds until the next completion.
interface shift_add_multiplier_if #(parameter int N = 8);
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           start;
  logic           busy;
  logic [2*N-1:0] product_out;
  logic           done;
  logic [1:0]     state_dbg;

  modport master (
    output a_in, b_in, start,
    input  busy, product_out, done, state_dbg
  );

  modport slave (
    input  a_in, b_in, start,
    output busy, product_out, done, state_dbg
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// An accepted start latches the operands. N busy cycles follow, and each one
// adds the shifted multiplicand when the current multiplier LSB is set. The
// final sum is registered into product_out together with a one-cycle done
// pulse. Latency is fixed at N+1 cycles, and start is honoured again in the
// DONE cycle so products can stream back to back.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_add_multiplier_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;
  logic           busy_r;
  logic           done_r;
  logic [2*N-1:0] product_r;
  logic [2*N-1:0] acc_next;
  logic           last_step;

  // Partial-product sum for the current busy step; on the final step this is the product.
  always_comb begin
    acc_next  = acc;
    last_step = (count == CW'(N - 1));
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  // Control FSM and datapath registers. The product is registered on the last busy edge so that done and product_out rise together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand  <= {{N{1'b0}}, bus.a_in};
            mplier <= bus.b_in;
            acc    <= '0;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= BUSY;
          end else begin
            state  <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_step) begin
            product_r <= acc_next;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.product_out = product_r;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier (N=8): table vectors, random operands
// against an arithmetic reference, back-to-back streaming, mid-run reset.
module tb_shift_add_multiplier;

  localparam int N = 8;

  logic clk;
  logic reset;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [2*N-1:0] exp_q[$];

  typedef struct {
    string          name;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    bit             poke;
  } vec_t;

  vec_t vecs[$];

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference model: plain unsigned product.
  function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*N-1:0];
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE or DONE. Runs one multiply and
  // checks latency, busy length, product, busy/done exclusivity and pulse width.
  // poke re-asserts start with 9*9 during the busy phase; it must be ignored.
  task automatic mult_check(input string name, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [2*N-1:0] want,
                            input bit poke);
    int lat;
    int busy_cnt;
    logic [2*N-1:0] e;
    exp_q.push_back(want);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) busy_cnt++;
      // operands may wander while busy
      bus.a_in = N'($urandom_range(0, 255));
      bus.b_in = N'($urandom_range(0, 255));
      if (poke && lat == 3) begin
        bus.a_in  = N'(9);
        bus.b_in  = N'(9);
        bus.start = 1'b1;
      end
      if (poke && lat == 5) bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check({name, "_latency"}, lat, N);
    check({name, "_busy_cycles"}, busy_cnt, N);
    check({name, "_product"}, bus.product_out, e);
    check({name, "_busy_with_done"}, bus.busy, 0);
    @(negedge clk);
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_product_hold"}, bus.product_out, e);
  endtask

  // ---------------- test ----------------
  initial begin
    int gap;
    int lat;
    int done_seen;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    total = 0;
    bad   = 0;
    vecs.push_back('{"a3b5",     8'd3,   8'd5,   16'd15,    1'b0});
    vecs.push_back('{"a255b255", 8'd255, 8'd255, 16'hFE01,  1'b0});
    vecs.push_back('{"a0b200",   8'd0,   8'd200, 16'd0,     1'b0});
    vecs.push_back('{"a200b0",   8'd200, 8'd0,   16'd0,     1'b0});
    vecs.push_back('{"a7b6poke", 8'd7,   8'd6,   16'd42,    1'b1});
    vecs.push_back('{"a1b1",     8'd1,   8'd1,   16'd1,     1'b0});
    vecs.push_back('{"a128b2",   8'd128, 8'd2,   16'd256,   1'b0});
    vecs.push_back('{"a255b1",   8'd255, 8'd1,   16'd255,   1'b0});

    reset     = 1'b1;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_product", bus.product_out, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      mult_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].poke);
    end

    // random operands against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mult_check("rand", ra, rb, ref_mult(ra, rb), 1'($urandom_range(0, 1)));
    end

    // back-to-back: start held high, new operands presented in the DONE cycle
    @(negedge clk);
    bus.a_in  = 8'd2;
    bus.b_in  = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, N);
    check("b2b_first_product", bus.product_out, ref_mult(8'd2, 8'd3));
    bus.a_in = 8'd4;
    bus.b_in = 8'd5;
    gap = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      gap++;
    end while (!bus.done && gap < 40);
    bus.start = 1'b0;
    check("b2b_gap", gap, N + 1);
    check("b2b_second_product", bus.product_out, ref_mult(8'd4, 8'd5));
    @(negedge clk);
    check("b2b_done_pulse", bus.done, 0);
    check("b2b_idle_busy", bus.busy, 0);

    // reset during the 4th busy cycle aborts the multiply
    bus.a_in  = 8'd3;
    bus.b_in  = 8'd5;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_busy", bus.busy, 0);
    check("mid_reset_done", bus.done, 0);
    check("mid_reset_product", bus.product_out, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("mid_reset_no_done", done_seen, 0);
    check("mid_reset_product_after", bus.product_out, 0);

    // recovery after the abort
    mult_check("after_reset", 8'd11, 8'd13, ref_mult(8'd11, 8'd13), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
